// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// WIDTH-bit register with clock enable and a 3-bit mode select. It supports
// hold, parallel load, logical shift left/right, rotate left/right,
// arithmetic shift right and clear. A saturating counter tracks shift
// operations since the last load/clear/reset. A one-cycle pulse on done marks
// the edge where a full word has been shifted.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (q=RESET_VAL, cnt=0, done=0)
//   en           clock enable; low holds q and cnt and clears done
//   mode         operation select (see mode constants below)
//   d            parallel load data
//   ser_in       serial input bit for the logical shifts
//   q            register contents
//   ser_out_msb  q[WIDTH-1], combinational from q
//   ser_out_lsb  q[0], combinational from q
//   cnt          shifts since last load/clear/reset, saturating at WIDTH
//   done         registered pulse on the edge where cnt goes WIDTH-1 -> WIDTH
// -----------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out_msb,
  output logic              ser_out_lsb,
  output logic [CNT_W-1:0]  cnt,
  output logic              done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg,    q_next;
  logic [CNT_W-1:0] cnt_reg,  cnt_next;
  logic             done_reg, done_next;

  // Shared by all shift modes: advance the counter unless saturated, and
  // raise done only on the step that reaches a full word. Further shifts
  // while saturated leave done low, so a new pulse needs a load or clear.
  logic [CNT_W-1:0] cnt_shift;
  logic             done_shift;

  always_comb begin
    cnt_shift  = (cnt_reg < CNT_FULL) ? cnt_reg + 1'b1 : CNT_FULL;
    done_shift = (cnt_reg == CNT_LAST);
  end

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next = q_reg;
        end
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_SHL: begin
          q_next    = {q_reg[WIDTH-2:0], ser_in};
          cnt_next  = cnt_shift;
          done_next = done_shift;
        end
        MODE_SHR: begin
          q_next    = {ser_in, q_reg[WIDTH-1:1]};
          cnt_next  = cnt_shift;
          done_next = done_shift;
        end
        MODE_ROL: begin
          q_next    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          cnt_next  = cnt_shift;
          done_next = done_shift;
        end
        MODE_ROR: begin
          q_next    = {q_reg[0], q_reg[WIDTH-1:1]};
          cnt_next  = cnt_shift;
          done_next = done_shift;
        end
        MODE_ASR: begin
          q_next    = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
          cnt_next  = cnt_shift;
          done_next = done_shift;
        end
        MODE_CLR: begin
          // Clear is an explicit zero, independent of RESET_VAL.
          q_next   = '0;
          cnt_next = '0;
        end
        default: begin
          q_next = q_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign q           = q_reg;
  assign cnt         = cnt_reg;
  assign done        = done_reg;
  assign ser_out_msb = q_reg[WIDTH-1];
  assign ser_out_lsb = q_reg[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Drives universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5) with the directed
// sequences followed by randomized stimulus. A behavioural model computes
// expected q/cnt/done with plain arithmetic on integers; every output is
// compared one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int         WIDTH     = 8;
  localparam logic [7:0] RESET_VAL = 8'hA5;
  localparam int         CNT_W     = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out_msb;
  logic             ser_out_lsb;
  logic [CNT_W-1:0] cnt;
  logic             done;

  universal_shift_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .d           (d),
    .ser_in      (ser_in),
    .q           (q),
    .ser_out_msb (ser_out_msb),
    .ser_out_lsb (ser_out_lsb),
    .cnt         (cnt),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done_seen = 0;

  // reference model state
  int unsigned m_q;
  int          m_cnt;
  int          m_done;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge, in plain integer arithmetic.
  task automatic model_edge(input int r, input int e, input int m, input int unsigned dv, input int s);
    int is_shift;
    if (r != 0) begin
      m_q = RESET_VAL; m_cnt = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (e == 0) return;
    is_shift = (m >= 2 && m <= 6);
    case (m)
      1: m_q = dv;
      2: m_q = ((m_q * 2) + s) % 256;
      3: m_q = (m_q / 2) + s * 128;
      4: m_q = ((m_q * 2) % 256) + (m_q / 128);
      5: m_q = (m_q / 2) + (m_q % 2) * 128;
      6: m_q = (m_q / 2) + (m_q >= 128 ? 128 : 0);
      7: m_q = 0;
      default: ;
    endcase
    if (m == 1 || m == 7) m_cnt = 0;
    if (is_shift != 0) begin
      if (m_cnt == WIDTH - 1) m_done = 1;
      if (m_cnt < WIDTH) m_cnt = m_cnt + 1;
    end
  endtask

  // One transaction: drive inputs, clock, update model, compare all outputs.
  task automatic step(input bit r, input bit e, input logic [2:0] m,
                      input logic [7:0] dv, input bit s);
    rst = r; en = e; mode = m; d = dv; ser_in = s;
    @(posedge clk);
    model_edge(int'(r), int'(e), int'(m), int'(dv), int'(s));
    #1;
    check("q",    q,           m_q);
    check("cnt",  cnt,         m_cnt);
    check("done", done,        m_done);
    check("msb",  ser_out_msb, m_q / 128);
    check("lsb",  ser_out_lsb, m_q % 2);
    if (done) n_done_seen++;
    $display("txn rst=%0b en=%0b mode=%0d d=%02h ser=%0b -> q=%02h cnt=%0d done=%0b",
             r, e, m, dv, s, q, cnt, done);
  endtask

  logic [7:0] sipo_bits;
  logic [7:0] piso_exp;
  int done_before;

  initial begin
    m_q = 0; m_cnt = 0; m_done = 0;
    rst = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hFF; ser_in = 1'b0;

    // 1: reset overrides a pending load, then the load lands.
    step(1, 1, 3'b001, 8'hFF, 0);
    step(1, 1, 3'b001, 8'hFF, 0);
    check("rst_q", q, 8'hA5);
    step(0, 1, 3'b001, 8'hFF, 0);
    check("load_ff", q, 8'hFF);

    // 2: rotate left a full word and one more.
    step(0, 1, 3'b001, 8'h81, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'b100, 8'h00, 0);
    check("rol8_q", q, 8'h81);
    check("rol8_done", done, 1);
    step(0, 1, 3'b100, 8'h00, 0);
    check("rol9_q", q, 8'h03);
    check("rol9_cnt", cnt, 8);
    check("rol9_done", done, 0);

    // 3: arithmetic and logical shifts.
    step(0, 1, 3'b001, 8'h80, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b110, 8'h00, 1);
    check("asr_q", q, 8'hF0);
    step(0, 1, 3'b011, 8'h00, 0);
    check("shr_q", q, 8'h78);
    step(0, 1, 3'b010, 8'h00, 1);
    check("shl_q", q, 8'hF1);
    check("shl_cnt", cnt, 5);

    // 4: enable low holds everything.
    step(0, 1, 3'b001, 8'h5A, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b010, 8'h00, 1);
    check("hold_q", q, 8'h5A);
    step(0, 1, 3'b111, 8'h00, 0);
    check("clr_q", q, 8'h00);

    // 5: SIPO, then a repeat run cut by reset on the 5th shift.
    sipo_bits = 8'b1011_0010;
    step(0, 1, 3'b111, 8'h00, 0);
    for (int i = 7; i >= 0; i--) step(0, 1, 3'b010, 8'h00, sipo_bits[i]);
    check("sipo_q", q, 8'hB2);
    check("sipo_done", done, 1);
    step(0, 1, 3'b111, 8'h00, 0);
    for (int i = 7; i >= 4; i--) step(0, 1, 3'b010, 8'h00, sipo_bits[i]);
    step(1, 1, 3'b010, 8'h00, sipo_bits[3]);
    check("sipo_rst_q", q, 8'hA5);
    check("sipo_rst_cnt", cnt, 0);

    // 6: PISO, serial LSB-first read before each edge.
    step(0, 1, 3'b001, 8'hC3, 0);
    piso_exp = 8'b1100_0011;
    done_before = n_done_seen;
    for (int i = 0; i < 8; i++) begin
      check("piso_lsb", ser_out_lsb, piso_exp[i]);
      step(0, 1, 3'b011, 8'h00, 0);
    end
    check("piso_q", q, 8'h00);
    check("piso_done_cnt", n_done_seen - done_before, 1);

    // Randomized phase, biased toward shifts so the counter saturates.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] rm;
      rm = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(2, 6)) : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rm,
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit register with clock enable and a mode select.
- Modes: parallel load, logical shift, rotate, arithmetic shift and clear.
- Tracks the number of shift operations since the last load and pulses done when a full word has been shifted.
- Serves as the common building block for SIPO/PISO converters and pipeline delay registers.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; when low, all state holds.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- ser_in  input  1  serial input bit for logical shifts.
- q  output  WIDTH  register contents.
- ser_out_msb  output  1  equals q[WIDTH-1] (combinational from q).
- ser_out_lsb  output  1  equals q[0] (combinational from q).
- cnt  output  CNT_W  shift operations since last load/clear/reset, saturating at WIDTH.
- done  output  1  one-cycle registered pulse when cnt reaches WIDTH.

Behaviour:
- One clock, synchronous active-high reset; all state updates only on rising clk.
- Priority per edge: rst, then en=0 (hold), then mode.
- Reset: q=RESET_VAL, cnt=0, done=0. Reset asserted mid-operation discards any operation that cycle.
- en=0: q and cnt hold; done=0 in the following cycle.
- Mode decode when en=1:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q=d.
  - 010 SHL: q={q[WIDTH-2:0], ser_in}.
  - 011 SHR: q={ser_in, q[WIDTH-1:1]}.
  - 100 ROL: q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q={q[0], q[WIDTH-1:1]}.
  - 110 ASR: q={q[WIDTH-1], q[WIDTH-1:1]}; ser_in is ignored.
  - 111 CLR: q=0, explicitly zero and not RESET_VAL.
- Latency: q reflects the operation on the edge after it is presented. ser_out_* follow q with no added delay.
- Counter:
  - LOAD or CLR: cnt=0.
  - Shift modes (010-110) with en=1: cnt=cnt+1 if cnt<WIDTH, otherwise cnt stays at WIDTH.
  - HOLD: cnt unchanged.
- done:
  - Asserted for exactly the one cycle in which cnt becomes WIDTH, i.e. the edge where cnt goes from WIDTH-1 to WIDTH.
  - Deasserted every other cycle, including further shifts while saturated.
  - A fresh pulse requires a LOAD or CLR first.
- All shifts are width-exact; no bit outside [WIDTH-1:0] is created.
- The counter never wraps.

Test Plan:
1. WIDTH=8, RESET_VAL=8'hA5. Assert rst for 2 cycles with en=1, mode=001, d=8'hFF -> q=8'hA5, cnt=0, done=0. Deassert rst -> next edge q=8'hFF.
2. LOAD 8'h81, then ROL x8 -> q sequence 03,06,0C,18,30,60,C0,81. cnt reaches 8 on the 8th edge with done=1 for that cycle only. A 9th ROL gives q=03, cnt=8, done=0.
3. LOAD 8'h80, then ASR x3 -> q=C0,E0,F0. Then SHR with ser_in=0 -> q=78. Then SHL with ser_in=1 -> q=F1. cnt=5.
4. LOAD 8'h5A, then en=0 with mode=010 for 3 cycles -> q=5A, cnt=0, done=0 throughout. Then CLR -> q=00, cnt=0.
5. SIPO: CLR, then SHL x8 with ser_in bits 1,0,1,1,0,0,1,0 -> q=8'hB2, done pulses on the 8th edge. Assert rst on the 5th shift edge of a repeat run -> q=RESET_VAL, cnt=0, no done pulse.
6. PISO: LOAD 8'hC3, then SHR x8 with ser_in=0 -> ser_out_lsb sampled before each edge reads 1,1,0,0,0,0,1,1. Final q=00, done pulse once.
